// File: rtl/pipe_addsub_pkg.sv
// Shared op-mode constants and the stage payload record for the segmented add/sub pipe.
// Vector fields are sized for the widest supported operand; narrower instances use the low bits.
package pipe_addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int MAX_W = 64;

    // One pipeline slot: completed low result bits, running carry and zero,
    // plus the operand bits that later stages still have to consume.
    typedef struct packed {
        logic             valid;
        logic             mode;
        logic             carry;
        logic             zero;
        logic             ovf;
        logic [MAX_W-1:0] res;
        logic [MAX_W-1:0] rem_a;
        logic [MAX_W-1:0] rem_b;
    } payload_t;

endpackage

// File: rtl/addsub_seg.sv
// One SEG-bit slice of the ripple chain: sum, carry-out and carry into its MSB.
module addsub_seg #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum  = full[W-1:0];
    assign cout = full[W];
    // The MSB sum bit is a^b^carry_in, so the incoming carry can be recovered from it.
    assign cmsb = sum[W-1] ^ a[W-1] ^ b[W-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: one carry segment per stage, valid/ready handshake
// with per-stage load enables so bubbles collapse and stalls propagate upstream.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int STAGES  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] A,
    input  logic [D_WIDTH-1:0] B,
    input  logic               Cin,
    input  logic               Sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] Result,
    output logic               Cout,
    output logic               Zero,
    output logic               Overflow,
    output logic               Sign
);

    localparam int SEG = D_WIDTH / STAGES;

    payload_t          chain_q [STAGES];
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] load;

    // A stage may capture when it is empty or when its occupant moves on downstream.
    always_comb begin
        load = '0;
        load[STAGES-1] = out_ready | ~vld[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            load[k] = ~vld[k] | load[k+1];
        end
    end

    assign in_ready = load[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        payload_t       src;
        payload_t       stage_d;
        payload_t       stage_q;
        logic [SEG-1:0] seg_a;
        logic [SEG-1:0] seg_b;
        logic [SEG-1:0] seg_sum;
        logic           seg_cout;
        logic           seg_cmsb;

        if (k == 0) begin : g_head
            // Subtraction is A + ~B + ~Cin, so the borrow-in enters the chain inverted.
            always_comb begin
                src       = '0;
                src.valid = in_valid;
                src.mode  = Sub;
                src.carry = (Sub == OP_SUB) ? ~Cin : Cin;
                src.zero  = 1'b1;
                src.rem_a = MAX_W'(A);
                src.rem_b = MAX_W'(B);
            end
        end else begin : g_body
            assign src = chain_q[k-1];
        end

        assign seg_a = src.rem_a[SEG-1:0];
        assign seg_b = (src.mode == OP_SUB) ? ~src.rem_b[SEG-1:0] : src.rem_b[SEG-1:0];

        addsub_seg #(.W(SEG)) u_seg (
            .a    (seg_a),
            .b    (seg_b),
            .cin  (src.carry),
            .sum  (seg_sum),
            .cout (seg_cout),
            .cmsb (seg_cmsb)
        );

        always_comb begin
            stage_d                  = src;
            stage_d.res[k*SEG +: SEG] = seg_sum;
            stage_d.carry            = seg_cout;
            stage_d.zero             = src.zero & ~(|seg_sum);
            stage_d.ovf              = seg_cmsb ^ seg_cout;
            stage_d.rem_a            = src.rem_a >> SEG;
            stage_d.rem_b            = src.rem_b >> SEG;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_q <= '0;
            end else if (load[k]) begin
                stage_q <= stage_d;
            end
        end

        assign chain_q[k] = stage_q;
        assign vld[k]     = stage_q.valid;
    end

    // Only the last stage's overflow is meaningful: its segment holds the word MSB.
    assign out_valid = vld[STAGES-1];
    assign Result    = chain_q[STAGES-1].res[D_WIDTH-1:0];
    assign Cout      = chain_q[STAGES-1].carry;
    assign Zero      = chain_q[STAGES-1].zero;
    assign Overflow  = chain_q[STAGES-1].ovf;
    assign Sign      = chain_q[STAGES-1].res[D_WIDTH-1];

endmodule
